debounce_pulse: RTL and testbench

DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

---
 rtl/debounce_pulse_if.sv | 25 ++
 rtl/debounce_pulse.sv | 103 ++++++++++
 tb/tb_debounce_pulse.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_pulse_if.sv
// Push-button debouncer signal bundle.
// The master drives the raw button; the slave returns level, pulses and busy.
interface debounce_pulse_if;
    logic btn_in;
    logic btn_level;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output btn_in,
        input  btn_level,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/debounce_pulse.sv
// Button debouncer: two-flop synchronizer, qualification FSM and counter.
// Emits a debounced level plus one-cycle rise/fall pulses.
module debounce_pulse #(
    parameter int CNT_MAX = 16
) (
    input logic             clk,
    input logic             reset,
    debounce_pulse_if.slave bus
);

    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_WAIT,
        S_HIGH,
        S_FALL_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          s1;
    logic          s2;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    // Qualify a level change over CNT_MAX stable samples; pulses last one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state)
                S_LOW: begin
                    if (s2) begin
                        state <= S_RISE_WAIT;
                        cnt   <= '0;
                    end
                end
                S_RISE_WAIT: begin
                    if (!s2) begin
                        state <= S_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_HIGH;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!s2) begin
                        state <= S_FALL_WAIT;
                        cnt   <= '0;
                    end
                end
                S_FALL_WAIT: begin
                    if (s2) begin
                        state <= S_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_LOW;
                        cnt     <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.btn_level = level_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.busy      = (state == S_RISE_WAIT) || (state == S_FALL_WAIT);

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse.
// Expected pulses go to a scoreboard queue; monitors pop and compare them.
module tb_debounce_pulse;

    typedef struct {
        logic is_rise;
        int   edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   nrise16 = 0;
    int   nfall16 = 0;
    logic prev4 = 1'b0;
    logic prev16 = 1'b0;

    exp_t q4[$];
    logic q16[$];

    debounce_pulse_if b4 ();
    debounce_pulse_if b16 ();

    debounce_pulse #(.CNT_MAX(4)) dut4 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b4)
    );

    debounce_pulse #(.CNT_MAX(16)) dut16 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    a_excl4 : assert property (@(posedge clk) !(b4.rise && b4.fall));
    a_excl16 : assert property (@(posedge clk) !(b16.rise && b16.fall));
    a_one4 : assert property (@(posedge clk) disable iff (!rst_n)
        (b4.rise || b4.fall) |=> !(b4.rise || b4.fall));
    a_one16 : assert property (@(posedge clk) disable iff (!rst_n)
        (b16.rise || b16.fall) |=> !(b16.rise || b16.fall));

    // Scoreboard monitor for the CNT_MAX=4 instance: kind and edge number.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (b4.rise || b4.fall) begin
            checks++;
            if (b4.rise && b4.fall) begin
                failures++;
                $display("FAIL pulse4_excl rise=%b fall=%b required not both", b4.rise, b4.fall);
            end else if (prev4) begin
                failures++;
                $display("FAIL pulse4_width edge=%0d pulse also high on previous edge", cyc);
            end else if (q4.size() == 0) begin
                failures++;
                $display("FAIL pulse4_unexpected edge=%0d rise=%b fall=%b required none", cyc, b4.rise, b4.fall);
            end else begin
                e = q4.pop_front();
                if (b4.rise !== e.is_rise || cyc !== e.edge_n) begin
                    failures++;
                    $display("FAIL pulse4 got rise=%b edge=%0d required rise=%b edge=%0d", b4.rise, cyc, e.is_rise, e.edge_n);
                end
            end
        end
        prev4 = b4.rise || b4.fall;
    end

    // Scoreboard monitor for the CNT_MAX=16 instance: pulse kind and alternation.
    always @(posedge clk) begin
        logic k;
        #1;
        if (b16.rise || b16.fall) begin
            checks++;
            if (b16.rise) nrise16++;
            if (b16.fall) nfall16++;
            if ((b16.rise && b16.fall) || prev16) begin
                failures++;
                $display("FAIL pulse16_shape edge=%0d rise=%b fall=%b", cyc, b16.rise, b16.fall);
            end else if (q16.size() == 0) begin
                failures++;
                $display("FAIL pulse16_unexpected edge=%0d rise=%b required none", cyc, b16.rise);
            end else begin
                k = q16.pop_front();
                if (b16.rise !== k) begin
                    failures++;
                    $display("FAIL pulse16_kind edge=%0d rise=%b required rise=%b", cyc, b16.rise, k);
                end
            end
        end
        prev16 = b16.rise || b16.fall;
    end

    task automatic drv4(input logic v, output int k);
        @(negedge clk);
        b4.btn_in = v;
        k = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drv16(input logic v);
        @(negedge clk);
        b16.btn_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4.btn_in = 1'b1;
        b16.btn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({b4.btn_level, b4.rise, b4.fall, b4.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b required 0000",
                     {b4.btn_level, b4.rise, b4.fall, b4.busy});
        end
        @(negedge clk);
        b4.btn_in = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle got %b required 00", {b4.btn_level, b4.busy});
        end
    endtask

    task automatic test_press();
        int k;
        int e;
        exp_t x;
        drv4(1'b1, k);
        x.is_rise = 1'b1;
        x.edge_n = k + 6;
        q4.push_back(x);
        for (int i = 1; i <= 8; i++) begin
            drv4(1'b1, e);
            checks++;
            if (b4.busy !== ((e >= k + 2) && (e <= k + 5))) begin
                failures++;
                $display("FAIL press_busy edge=k+%0d got %b required %b", e - k, b4.busy,
                         (e >= k + 2) && (e <= k + 5));
            end
            checks++;
            if (b4.btn_level !== (e >= k + 6)) begin
                failures++;
                $display("FAIL press_level edge=k+%0d got %b required %b", e - k, b4.btn_level, e >= k + 6);
            end
        end
    endtask

    task automatic test_release();
        int k;
        exp_t x;
        drv4(1'b0, k);
        x.is_rise = 1'b0;
        x.edge_n = k + 6;
        q4.push_back(x);
        repeat (9) drv4(1'b0, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL release_level got %b required 00", {b4.btn_level, b4.busy});
        end
    endtask

    task automatic test_bounce_press();
        int k;
        repeat (3) drv4(1'b1, k);
        repeat (10) drv4(1'b0, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL bounce_press got level,busy=%b required 00", {b4.btn_level, b4.busy});
        end
    endtask

    task automatic test_bounce_release();
        int k;
        exp_t x;
        drv4(1'b1, k);
        x.is_rise = 1'b1;
        x.edge_n = k + 6;
        q4.push_back(x);
        repeat (9) drv4(1'b1, k);
        repeat (3) drv4(1'b0, k);
        drv4(1'b1, k);
        drv4(1'b0, k);
        x.is_rise = 1'b0;
        x.edge_n = k + 6;
        q4.push_back(x);
        repeat (9) drv4(1'b0, k);
        checks++;
        if ({b4.btn_level, b4.busy, q4.size() == 0} !== 3'b001) begin
            failures++;
            $display("FAIL bounce_release got level,busy,drained=%b required 001",
                     {b4.btn_level, b4.busy, q4.size() == 0});
        end
    endtask

    task automatic test_reset_mid();
        int k;
        repeat (4) drv4(1'b1, k);
        checks++;
        if (b4.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got %b required 1", b4.busy);
        end
        #2;
        rst_n = 1'b0;
        b4.btn_in = 1'b0;
        #1;
        checks++;
        if ({b4.btn_level, b4.rise, b4.fall, b4.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset got %b required 0000",
                     {b4.btn_level, b4.rise, b4.fall, b4.busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) drv4(1'b0, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_after got %b required 00", {b4.btn_level, b4.busy});
        end
    endtask

    task automatic test_reset_high();
        int k;
        exp_t x;
        @(negedge clk);
        rst_n = 1'b0;
        b4.btn_in = 1'b1;
        repeat (3) drv4(1'b1, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL high_in_reset got %b required 00", {b4.btn_level, b4.busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        x.is_rise = 1'b1;
        x.edge_n = cyc + 1 + 6;
        q4.push_back(x);
        repeat (10) drv4(1'b1, k);
        checks++;
        if (b4.btn_level !== 1'b1) begin
            failures++;
            $display("FAIL high_release level got %b required 1", b4.btn_level);
        end
    endtask

    task automatic test_hold();
        int k;
        exp_t x;
        repeat (40) drv4(1'b1, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b10) begin
            failures++;
            $display("FAIL hold_high got %b required 10", {b4.btn_level, b4.busy});
        end
        drv4(1'b0, k);
        x.is_rise = 1'b0;
        x.edge_n = k + 6;
        q4.push_back(x);
        repeat (40) drv4(1'b0, k);
        checks++;
        if ({b4.btn_level, b4.busy} !== 2'b00) begin
            failures++;
            $display("FAIL hold_low got %b required 00", {b4.btn_level, b4.busy});
        end
    endtask

    task automatic test_random_bounce();
        logic v;
        int   t;
        int   n;
        for (int p = 0; p < 40; p++) begin
            v = (p % 2 == 0);
            q16.push_back(v);
            t = 0;
            while (t < 10) begin
                drv16(v);
                t++;
                if (t < 7 && $urandom_range(0, 1) == 1) begin
                    n = $urandom_range(1, 3);
                    repeat (n) drv16(!v);
                    t += n;
                end
            end
            repeat (40 - t) drv16(v);
        end
        repeat (5) drv16(1'b0);
        checks++;
        if (nrise16 !== 20 || nfall16 !== 20) begin
            failures++;
            $display("FAIL random_counts rise=%0d fall=%0d required 20 and 20", nrise16, nfall16);
        end
    endtask

    task automatic test_drained();
        checks++;
        if (q4.size() !== 0 || q16.size() !== 0) begin
            failures++;
            $display("FAIL missing_pulses pending4=%0d pending16=%0d required 0 and 0",
                     q4.size(), q16.size());
        end
    endtask

    initial begin
        b4.btn_in = 1'b0;
        b16.btn_in = 1'b0;
        test_reset();
        test_press();
        test_release();
        test_bounce_press();
        test_bounce_release();
        test_reset_mid();
        test_reset_high();
        test_hold();
        test_random_bounce();
        test_drained();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
